// File: rtl/fdivsqrt_seq_ctrl_if.sv
// Handshake bundle between issue/hazard logic and the divide/sqrt sequencing controller.
// The master side issues requests; the slave side is the controller.
interface fdivsqrt_seq_ctrl_if #(
    parameter int unsigned CNTW = 5
);
    logic            StartE;
    logic            SqrtE;
    logic [1:0]      FmtE;
    logic            SpecialCaseE;
    logic            StallM;
    logic            FlushE;
    logic            ReadyE;
    logic            IFDivStartE;
    logic            FDivBusyE;
    logic            FDivDoneE;
    logic [CNTW-1:0] IterLeft;

    modport master (
        output StartE, SqrtE, FmtE, SpecialCaseE, StallM, FlushE,
        input  ReadyE, IFDivStartE, FDivBusyE, FDivDoneE, IterLeft
    );

    modport slave (
        input  StartE, SqrtE, FmtE, SpecialCaseE, StallM, FlushE,
        output ReadyE, IFDivStartE, FDivBusyE, FDivDoneE, IterLeft
    );
endinterface

// File: rtl/fdivsqrt_seq_ctrl.sv
// Sequencing controller for the radix-2^LOGR divide/sqrt iteration datapath: issues the load
// pulse, enables the iteration registers for a format-dependent cycle count, then flags done.
module fdivsqrt_seq_ctrl #(
    parameter int unsigned LOGR        = 2,
    parameter int unsigned DIVCOPIES   = 2,
    parameter int unsigned Q_SUPPORTED = 1,
    parameter int unsigned CNTW        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    fdivsqrt_seq_ctrl_if.slave   bus
);

    localparam int unsigned BitsPerCycle = LOGR * DIVCOPIES;

    function automatic int unsigned iter_cycles(input int unsigned nf);
        return (nf + 3 + BitsPerCycle - 1) / BitsPerCycle;
    endfunction

    // Counter load values are N-1 so that exactly N BUSY cycles elapse.
    localparam logic [CNTW-1:0] CntS = CNTW'(iter_cycles(23) - 1);
    localparam logic [CNTW-1:0] CntD = CNTW'(iter_cycles(52) - 1);
    localparam logic [CNTW-1:0] CntH = CNTW'(iter_cycles(10) - 1);
    localparam logic [CNTW-1:0] CntQ = CNTW'(iter_cycles(112) - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] cnt_load;
    logic            accept;
    logic            unused_sqrt;

    // Square root and divide share the same iteration count.
    assign unused_sqrt = bus.SqrtE;

    always_comb begin
        cnt_load = CntD;
        case (bus.FmtE)
            2'b00:   cnt_load = CntS;
            2'b01:   cnt_load = CntD;
            2'b10:   cnt_load = CntH;
            default: cnt_load = (Q_SUPPORTED != 0) ? CntQ : CntD;
        endcase
    end

    assign accept = (state_q == StIdle) & bus.StartE & ~bus.FlushE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.SpecialCaseE) begin
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = cnt_load;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (!bus.StallM) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Flush overrides everything, including a stalled DONE.
        if (bus.FlushE) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_comb begin
        bus.ReadyE      = (state_q == StIdle);
        // Gated by reset so no load pulse escapes while reset is held.
        bus.IFDivStartE = accept & ~bus.SpecialCaseE & reset;
        bus.FDivBusyE   = bus.IFDivStartE | (state_q == StBusy);
        bus.FDivDoneE   = (state_q == StDone) & ~bus.FlushE;
        bus.IterLeft    = cnt_q;
    end

endmodule

// File: doc/fdivsqrt_seq_ctrl.md
Name: fdivsqrt_seq_ctrl

Overview:
- Sequencing controller for the radix-2^LOGR divide/square-root iteration datapath.
- Accepts a start request, generates the one-cycle load pulse (IFDivStartE) and the per-cycle register enable (FDivBusyE) for the iteration registers.
- Counts the format-dependent number of iterations, then signals completion to the post-processing stage.
- Sits in the FPU execute stage between issue/hazard logic and the iteration datapath.

Parameters:
- LOGR, 2, log2 of radix (1 = radix 2, 2 = radix 4)
- DIVCOPIES, 2, recurrence stages evaluated per cycle
- Q_SUPPORTED, 1, quad format present; when 0, FmtE=2'b11 is treated as double
- CNTW, 5, iteration counter width; must hold the largest cycle count minus 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- StartE  in  1  divide/sqrt request valid
- SqrtE  in  1  1 = square root, 0 = divide (no effect on cycle count)
- FmtE  in  2  precision: 00 single, 01 double, 10 half, 11 quad
- SpecialCaseE  in  1  result determined without iteration (zero/inf/NaN/div-by-zero)
- StallM  in  1  downstream stall; holds the completed result
- FlushE  in  1  abort the current operation
- ReadyE  out  1  controller idle, may accept StartE
- IFDivStartE  out  1  load pulse for the iteration registers/muxes
- FDivBusyE  out  1  iteration register enable / pipeline stall
- FDivDoneE  out  1  result available for post-processing
- IterLeft  out  CNTW  remaining iteration cycles (debug/verification)

Behaviour:
- States: IDLE, BUSY, DONE. Reset (reset=0, asynchronous) forces IDLE with counter=0.
- Values while in reset: ReadyE=1, IFDivStartE=0, FDivBusyE=0, FDivDoneE=0, IterLeft=0.
- Nf per format: S=23, D=52, H=10, Q=112.
- N = ceil((Nf+3)/(LOGR*DIVCOPIES)). Defaults: S=7, D=14, H=4, Q=29.
- N is computed combinationally from FmtE, sampled only on the accepting cycle.
- ReadyE = (state==IDLE).
- IDLE:
  - StartE & ~FlushE & ~SpecialCaseE: IFDivStartE=1 combinationally in that cycle; next state BUSY; counter <= N-1.
  - StartE & ~FlushE & SpecialCaseE: IFDivStartE=0; next state DONE directly (1-cycle latency).
  - StartE & FlushE: ignored; remain IDLE.
- BUSY:
  - One iteration per cycle.
  - counter != 0: counter decrements by 1.
  - counter == 0: next state DONE.
  - Exactly N BUSY cycles.
- FDivBusyE = IFDivStartE | (state==BUSY).
- DONE:
  - FDivDoneE=1.
  - StallM=1: remain DONE, counter holds 0, FDivBusyE stays 0 so iteration registers freeze.
  - StallM=0: next state IDLE.
  - StartE is ignored in DONE; a new operation is accepted no earlier than the cycle after the return to IDLE.
- Latency: accept at cycle 0 → BUSY cycles 1..N → FDivDoneE in cycle N+1 → ReadyE in cycle N+2 (no stall).
- FlushE:
  - In any state, next state is IDLE and counter <= 0.
  - In the flush cycle, IFDivStartE is forced 0 and FDivDoneE is forced 0.
  - FDivBusyE may still be 1 in a BUSY flush cycle; this is harmless.
- Simultaneous FlushE and StallM: flush wins.
- FmtE/SqrtE changing after acceptance: no effect.
- Q_SUPPORTED=0: FmtE=11 yields N=14.
- Counter never wraps: it decrements only in BUSY while nonzero.
- IterLeft equals the counter.

Test Plan:
- Reset/idle: reset low mid-BUSY with counter=9 → same cycle ReadyE=1, FDivBusyE=0, IterLeft=0. After release, a new StartE is accepted.
- Double divide: FmtE=01, StartE pulse at cycle 0 → IFDivStartE=1 in cycle 0 only; FDivBusyE=1 cycles 0–14; IterLeft 13→0 over cycles 1–14; FDivDoneE=1 in cycle 15; ReadyE=1 in cycle 16.
- Per-format counts: S/H/Q sqrt with SqrtE=1 → exactly 7/4/29 BUSY cycles. With Q_SUPPORTED=0, FmtE=11 → 14 BUSY cycles.
- Special case: StartE with SpecialCaseE=1 at cycle 0 → IFDivStartE=0, FDivBusyE=0; FDivDoneE=1 in cycle 1.
- Stall at done: single op; StallM=1 for 3 cycles starting at the DONE cycle → FDivDoneE held 4 cycles, FDivBusyE=0, StartE during DONE ignored. IDLE on the cycle after StallM drops.
- Flush: FlushE in BUSY cycle 5 of a double op → IDLE next cycle, FDivDoneE never asserts. StartE with FlushE in IDLE is ignored. A new single op then completes in 7 BUSY cycles.
